amp_bin_normalizer: RTL

//  Receiving end of the amplitude-preprocessor output interface. Captures one frame of floored

---
 rtl/amp_pkg.sv | 23 ++
 rtl/amp_serial_div.sv | 60 ++++++
 rtl/amp_bin_normalizer.sv | 111 +++++++++++
 3 files changed

// File: rtl/amp_pkg.sv
// Shared widths, types and constants for the amplitude bin normalizer.
// Output fractions are unsigned 1.D values; NORM_ONE represents 1.0.
package amp_pkg;

  localparam int W       = 6;
  localparam int D       = 10;
  localparam int BIN_QTY = 12;
  localparam int AMP_W   = W + D;
  localparam int IDX_W   = $clog2(BIN_QTY);
  localparam int SUM_W   = AMP_W + IDX_W;
  localparam int CNT_W   = $clog2(D + 2);

  typedef logic [D:0] norm_t;

  localparam norm_t NORM_ONE = norm_t'(1) << D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_OUT
  } state_e;

endpackage

// File: rtl/amp_serial_div.sv
// Restoring divider producing floor(num*2^D/den) over D+1 cycles.
// Zero divisor or skip yields 0 at once; num > den clamps to NORM_ONE.
module amp_serial_div
  import amp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             skip_i,
  input  logic [AMP_W-1:0] num_i,
  input  logic [SUM_W-1:0] den_i,
  output logic             done_o,
  output norm_t            quo_o
);

  localparam logic [CNT_W-1:0] ITER = CNT_W'(D + 1);

  logic [SUM_W:0]   rem_q;
  logic [SUM_W-1:0] den_q;
  norm_t            quo_q;
  logic             clamp_q;
  logic [CNT_W-1:0] cnt_q;

  logic             ge;
  logic [SUM_W:0]   rsub;
  logic             bypass;

  always_comb begin
    ge     = rem_q >= {1'b0, den_q};
    rsub   = ge ? (rem_q - {1'b0, den_q}) : rem_q;
    bypass = skip_i || (den_i == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q   <= '0;
      den_q   <= '0;
      quo_q   <= '0;
      clamp_q <= 1'b0;
      cnt_q   <= ITER;
    end else if (start_i) begin
      den_q   <= den_i;
      rem_q   <= {{(SUM_W + 1 - AMP_W){1'b0}}, num_i};
      quo_q   <= '0;
      clamp_q <= !bypass && (SUM_W'(num_i) > den_i);
      cnt_q   <= bypass ? ITER : '0;
    end else if (cnt_q != ITER) begin
      // Remainder stays below den, so the doubled value fits SUM_W+1 bits.
      rem_q <= {rsub[SUM_W-1:0], 1'b0};
      quo_q <= {quo_q[D-1:0], ge};
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    done_o = (cnt_q == ITER);
    quo_o  = clamp_q ? NORM_ONE : quo_q;
  end

endmodule

// File: rtl/amp_bin_normalizer.sv
// Captures a frame of bin amplitudes and streams amp/sum per bin.
// Define AMP_NORM_SKIP_ZERO_EN to let zero-amplitude bins bypass division.
module amp_bin_normalizer
  import amp_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst,
  input  logic [BIN_QTY-1:0][AMP_W-1:0]   noteAmplitudes_i,
  input  logic [SUM_W-1:0]                amplitudeSum_i,
  input  logic                            data_v_i,
  output norm_t                           norm_o,
  output logic [IDX_W-1:0]                bin_idx_o,
  output logic                            last_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic                            busy_o,
  output logic                            overrun_o
);

  state_e                         state_q;
  logic [BIN_QTY-1:0][AMP_W-1:0]  amps_q;
  logic [SUM_W-1:0]               sum_q;
  logic [IDX_W-1:0]               idx_q;

  logic [IDX_W-1:0]               nxt_idx;
  logic                           cap;
  logic                           xfer;
  logic                           div_start;
  logic                           div_skip;
  logic [AMP_W-1:0]               div_num;
  logic [SUM_W-1:0]               div_den;
  logic                           div_done;
  norm_t                          div_quo;

  always_comb begin
    nxt_idx   = (idx_q == IDX_W'(BIN_QTY - 1)) ? '0 : idx_q + 1'b1;
    cap       = (state_q == ST_IDLE) && data_v_i;
    xfer      = (state_q == ST_OUT) && valid_o && ready_i;
    div_start = cap || (xfer && !last_o);
    div_num   = cap ? noteAmplitudes_i[0] : amps_q[nxt_idx];
    div_den   = cap ? amplitudeSum_i : sum_q;
`ifdef AMP_NORM_SKIP_ZERO_EN
    div_skip  = (div_num == '0);
`else
    div_skip  = 1'b0;
`endif
  end

  amp_serial_div u_div (
    .clk     (clk),
    .rst     (rst),
    .start_i (div_start),
    .skip_i  (div_skip),
    .num_i   (div_num),
    .den_i   (div_den),
    .done_o  (div_done),
    .quo_o   (div_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      amps_q    <= '0;
      sum_q     <= '0;
      idx_q     <= '0;
      norm_o    <= '0;
      bin_idx_o <= '0;
      last_o    <= 1'b0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      // Frames arriving outside IDLE, even on the final transfer, are dropped.
      overrun_o <= data_v_i && (state_q != ST_IDLE);
      unique case (state_q)
        ST_IDLE: begin
          if (data_v_i) begin
            amps_q  <= noteAmplitudes_i;
            sum_q   <= amplitudeSum_i;
            idx_q   <= '0;
            state_q <= ST_DIV;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            norm_o    <= div_quo;
            bin_idx_o <= idx_q;
            last_o    <= (idx_q == IDX_W'(BIN_QTY - 1));
            valid_o   <= 1'b1;
            state_q   <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (xfer) begin
            valid_o <= 1'b0;
            if (last_o) begin
              last_o  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q   <= nxt_idx;
              state_q <= ST_DIV;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule
